// File: rtl/pc_fetch_unit.sv
// Program counter / next-PC stage feeding a word-indexed instruction memory.
// Optional PC_PERF_CNT_EN adds fetch and stall performance counters.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_off_i,
  input  logic        jal_i,
  input  logic [31:0] jal_off_i,
  input  logic        jalr_i,
  input  logic [31:0] jalr_tgt_i,
  input  logic        halt_i,
  input  logic [31:0] instr_i,
  output logic [31:0] imem_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic        fetch_valid_o,
  output logic        fault_o,
  output logic        halted_o
`ifdef PC_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) << 2;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t             state, state_nxt;
  logic        [31:0] pc_p0, pc_nxt;
  logic               fault_p0, fault_nxt;
  logic signed [31:0] br_off, jal_off;
  logic        [31:0] target;

  assign br_off  = branch_off_i;
  assign jal_off = jal_off_i;

  function automatic logic [31:0] pc_add(input logic [31:0] base,
                                         input logic signed [31:0] off);
    logic signed [31:0] sum;
    sum = $signed(base) + off;
    return $unsigned(sum);
  endfunction

  function automatic logic target_bad(input logic [31:0] t);
    return (t[1:0] != 2'b00) || ({1'b0, t} >= PC_LIMIT);
  endfunction

  always_comb begin
    target = pc_p0 + 32'd4;
    if (jalr_i)              target = jalr_tgt_i & 32'hFFFF_FFFE;
    else if (jal_i)          target = pc_add(pc_p0, jal_off);
    else if (branch_taken_i) target = pc_add(pc_p0, br_off);
  end

  // Halt outranks any redirect; a bad target leaves the PC where it was.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_p0;
    fault_nxt = fault_p0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (!stall_i) begin
          if (halt_i) begin
            state_nxt = HALT;
          end else if (target_bad(target)) begin
            fault_nxt = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_nxt = target;
          end
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc_p0    <= RESET_PC;
      fault_p0 <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_p0    <= pc_nxt;
      fault_p0 <= fault_nxt;
    end
  end

  assign fetch_valid_o = (state == RUN);
  assign halted_o      = (state == HALT);
  assign fault_o       = fault_p0;
  assign pc_o          = pc_p0;
  assign pc_plus4_o    = pc_p0 + 32'd4;
  assign imem_addr_o   = {2'b00, pc_p0[31:2]};
  assign instr_o       = fetch_valid_o ? instr_i : NOP;

`ifdef PC_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if (state == RUN) begin
      if (stall_i) stall_cnt <= stall_cnt + 32'd1;
      else         fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt;
  assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, br = 1'b0, jal = 1'b0, jalr = 1'b0, halt = 1'b0;
  logic [31:0] br_off = '0, jal_off = '0, jalr_tgt = '0;
  logic [31:0] instr, imem_addr, pc, pc4, instr_out;
  logic        valid, fault, halted;
`ifdef PC_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  logic [130:0] exp_q[$];
  int           cyc_q[$];
  string        name_q[$];

  // Instruction memory model: word contents tagged by address.
  assign instr = 32'hA000_0000 | imem_addr;

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall),
    .branch_taken_i(br), .branch_off_i(br_off),
    .jal_i(jal), .jal_off_i(jal_off),
    .jalr_i(jalr), .jalr_tgt_i(jalr_tgt),
    .halt_i(halt), .instr_i(instr),
    .imem_addr_o(imem_addr), .pc_o(pc), .pc_plus4_o(pc4),
    .instr_o(instr_out), .fetch_valid_o(valid),
    .fault_o(fault), .halted_o(halted)
`ifdef PC_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt), .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; br = 1'b0; jal = 1'b0; jalr = 1'b0; halt = 1'b0;
    br_off = '0; jal_off = '0; jalr_tgt = '0;
  endtask

  task automatic expect_st(input string nm, input logic [31:0] p,
                           input logic v, input logic f, input logic h);
    logic [31:0] ins;
    ins = v ? (32'hA000_0000 | (p >> 2)) : 32'h0000_0013;
    exp_q.push_back({p >> 2, p, p + 32'd4, ins, v, f, h});
    cyc_q.push_back(cyc);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    logic [130:0] e, got;
    string nm;
    got = {imem_addr, pc, pc4, instr_out, valid, fault, halted};
    while (exp_q.size() > 0 && cyc_q[0] <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      void'(cyc_q.pop_front());
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL %s cyc=%0d got addr=%h pc=%h pc4=%h instr=%h v=%b f=%b h=%b, want addr=%h pc=%h pc4=%h instr=%h v=%b f=%b h=%b",
                 nm, cyc, got[130:99], got[98:67], got[66:35], got[34:3], got[2], got[1], got[0],
                 e[130:99], e[98:67], e[66:35], e[34:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    // Test 1: boot then sequential fetch
    step(); rst_n = 1'b1; expect_st("boot", 32'h0, 1'b0, 1'b0, 1'b0);
    step(); expect_st("seq0", 32'd0, 1'b1, 1'b0, 1'b0);
    step(); expect_st("seq4", 32'd4, 1'b1, 1'b0, 1'b0);
    step(); expect_st("seq8", 32'd8, 1'b1, 1'b0, 1'b0);
    step(); br = 1'b1; br_off = -32'sd4; expect_st("seq12", 32'd12, 1'b1, 1'b0, 1'b0);
    // Test 2: backward branch
    step(); idle(); br = 1'b1; br_off = -32'sd8; expect_st("br_back_a", 32'd8, 1'b1, 1'b0, 1'b0);
    step(); idle(); expect_st("br_back_b", 32'd0, 1'b1, 1'b0, 1'b0);
    // Test 3: JAL outranks branch
    step(); jal = 1'b1; jal_off = 32'd12; br = 1'b1; br_off = 32'd4;
    expect_st("jal_cycle", 32'd4, 1'b1, 1'b0, 1'b0);
    step(); idle(); br = 1'b1; br_off = -32'sd4; expect_st("jal_prio", 32'd16, 1'b1, 1'b0, 1'b0);
    // Test 4: JALR clears bit0, then misaligned JALR faults
    step(); idle(); jalr = 1'b1; jalr_tgt = 32'h29; jal = 1'b1; jal_off = 32'd4;
    expect_st("jalr_pc12", 32'd12, 1'b1, 1'b0, 1'b0);
    step(); idle(); jalr = 1'b1; jalr_tgt = 32'h22; expect_st("jalr_tgt", 32'h28, 1'b1, 1'b0, 1'b0);
    step(); idle(); jal = 1'b1; jal_off = 32'd4; expect_st("jalr_fault", 32'h28, 1'b0, 1'b1, 1'b1);
    step(); idle(); expect_st("halt_frozen", 32'h28, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    step(); rst_n = 1'b1; expect_st("reset_clears", 32'h0, 1'b0, 1'b0, 1'b0);
    // Test 5: stall holds PC and ignores redirect and halt
    step(); expect_st("r2_seq0", 32'd0, 1'b1, 1'b0, 1'b0);
    step(); expect_st("r2_seq4", 32'd4, 1'b1, 1'b0, 1'b0);
    step(); stall = 1'b1; jal = 1'b1; jal_off = 32'd100; expect_st("stall1", 32'd8, 1'b1, 1'b0, 1'b0);
    step(); halt = 1'b1; expect_st("stall2", 32'd8, 1'b1, 1'b0, 1'b0);
    step(); halt = 1'b0; expect_st("stall3", 32'd8, 1'b1, 1'b0, 1'b0);
    step(); stall = 1'b0; jal_off = 32'd4; expect_st("stall_rel", 32'd8, 1'b1, 1'b0, 1'b0);
    // halt beats a simultaneous branch
    step(); idle(); halt = 1'b1; br = 1'b1; br_off = 32'd8; expect_st("jal_after_stall", 32'd12, 1'b1, 1'b0, 1'b0);
    step(); idle(); expect_st("halt_req", 32'd12, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    // Test 6: sequential run to the top of memory
    step(); rst_n = 1'b1; expect_st("r3_boot", 32'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      step(); expect_st("run_up", 32'(k * 4), 1'b1, 1'b0, 1'b0);
    end
    step(); expect_st("wrap_fault", 32'd124, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    step(); expect_st("final_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    step(); expect_st("final_reset_hold", 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
